// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake, flags and accumulator
// Optional saturating add/sub: define ALU_PIPE_SAT_EN.
module alu_pipe #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             acc_sel_i,
    input  logic             acc_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             res_c;
    logic             res_v;
    logic             accept;

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign acc_o      = acc;

    always_comb begin
        op_a  = acc_sel_i ? acc : a_i;
        sum   = {1'b0, op_a} + {1'b0, b_i};
        diff  = {1'b0, op_a} - {1'b0, b_i};
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_i)
            3'b000: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (op_a[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
                if (sum[WIDTH]) res = '1;
`endif
            end
            3'b001: begin
                // diff[WIDTH] is the borrow out of the unsigned subtraction
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (op_a[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
                if (diff[WIDTH]) res = '0;
`endif
            end
            3'b010: begin
                res   = {b_i[WIDTH-2:0], 1'b0};
                res_c = b_i[WIDTH-1];
            end
            3'b011: begin
                res   = {1'b0, b_i[WIDTH-1:1]};
                res_c = b_i[0];
            end
            3'b100:  res = op_a & b_i;
            3'b101:  res = op_a | b_i;
            3'b110:  res = op_a ^ b_i;
            default: res = {{(WIDTH-1){1'b0}}, (op_a == b_i)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_o <= 1'b0;
            alu_o       <= '0;
            zero_o      <= 1'b0;
            carry_o     <= 1'b0;
            ovf_o       <= 1'b0;
            acc         <= ACC_RST;
        end else begin
            if (accept) begin
                out_valid_o <= 1'b1;
                alu_o       <= res;
                zero_o      <= (res == '0);
                carry_o     <= res_c;
                ovf_o       <= res_v;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            // clear wins over the accept update but the transaction still used the old acc
            if (acc_clr_i) begin
                acc <= ACC_RST;
            end else if (accept) begin
                acc <= res;
            end
        end
    end

endmodule
